// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter: START/RUN/HALT sequencing, branch redirect, stall and consumed-instruction count.
// Optional misaligned-branch trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
`ifndef WORD
`define WORD 32
`endif

module fetch_pc_unit #(
  parameter logic [`WORD-1:0] RESET_PC  = `WORD'(0),
  parameter int unsigned      MEM_BYTES = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [`WORD-1:0] branch_target,
  output logic [`WORD-1:0] pc,
  output logic             fetch_valid,
  output logic             halted,
  output logic             fault,
  output logic [`WORD-1:0] fetch_count
);

  localparam logic [`WORD-1:0] MEM_LIMIT = `WORD'(MEM_BYTES);
  localparam logic [`WORD-1:0] ALIGN_MASK = ~`WORD'(3);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e           state_q;
  logic [`WORD-1:0] pc_q;
  logic [`WORD-1:0] cnt_q;
  logic             fetch_valid_q;
  logic             halted_q;
  logic             fault_q;

  logic [`WORD-1:0] seq_pc_d;
  logic [`WORD-1:0] br_pc_d;
  logic             br_misalign_d;

  // Sequential and redirect candidates; the range checks compare these at full width.
  always_comb begin
    seq_pc_d = pc_q + `WORD'(4);
`ifdef FETCH_MISALIGN_TRAP_EN
    br_pc_d       = branch_target;
    br_misalign_d = (branch_target[1:0] != 2'b00);
`else
    br_pc_d       = branch_target & ALIGN_MASK;
    br_misalign_d = 1'b0;
`endif
  end

  // Fetch FSM with all outputs held in registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_START;
      pc_q          <= RESET_PC & ALIGN_MASK;
      cnt_q         <= `WORD'(0);
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_START: begin
          state_q       <= ST_RUN;
          fetch_valid_q <= 1'b1;
        end
        ST_RUN: begin
          if (branch_taken) begin
            cnt_q <= cnt_q + `WORD'(1);
            if (br_misalign_d) begin
              fault_q       <= 1'b1;
              state_q       <= ST_HALT;
              fetch_valid_q <= 1'b0;
              halted_q      <= 1'b1;
            end else if (br_pc_d >= MEM_LIMIT) begin
              state_q       <= ST_HALT;
              fetch_valid_q <= 1'b0;
              halted_q      <= 1'b1;
            end else begin
              pc_q <= br_pc_d;
            end
          end else if (stall) begin
            pc_q  <= pc_q;
            cnt_q <= cnt_q;
          end else if (seq_pc_d >= MEM_LIMIT) begin
            // Last word consumed; pc stays on it.
            cnt_q         <= cnt_q + `WORD'(1);
            state_q       <= ST_HALT;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else begin
            pc_q  <= seq_pc_d;
            cnt_q <= cnt_q + `WORD'(1);
          end
        end
        ST_HALT: begin
          state_q       <= ST_HALT;
          fetch_valid_q <= 1'b0;
          halted_q      <= 1'b1;
        end
        default: begin
          state_q       <= ST_HALT;
          fetch_valid_q <= 1'b0;
          halted_q      <= 1'b1;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed plan followed by randomized traffic against a rule-level model.
`ifndef WORD
`define WORD 32
`endif

module tb_fetch_pc_unit;

  localparam int unsigned MEM = 256;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             stall = 1'b0;
  logic             branch_taken = 1'b0;
  logic [`WORD-1:0] branch_target = '0;
  logic [`WORD-1:0] pc;
  logic             fetch_valid;
  logic             halted;
  logic             fault;
  logic [`WORD-1:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a phase name plus the architectural values the spec talks about.
  string            m_phase = "START";
  logic [`WORD-1:0] m_pc    = '0;
  logic [`WORD-1:0] m_cnt   = '0;
  logic             m_fault = 1'b0;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  fetch_pc_unit #(.RESET_PC(`WORD'(0)), .MEM_BYTES(MEM)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc), .fetch_valid(fetch_valid),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [`WORD-1:0] obs, input logic [`WORD-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply the spec's per-edge rules to the model using the inputs present at the edge.
  task automatic model_edge();
    longint unsigned t;
    if (rst) begin
      m_phase = "START"; m_pc = '0; m_cnt = '0; m_fault = 1'b0;
    end else if (m_phase == "START") begin
      m_phase = "RUN";
    end else if (m_phase == "RUN") begin
      if (branch_taken) begin
        m_cnt = m_cnt + 1;
        t = longint'(branch_target);
        if (TRAP && (t % 4 != 0)) begin
          m_fault = 1'b1; m_phase = "HALT";
        end else begin
          t = t - (t % 4);
          if (t >= MEM) m_phase = "HALT";
          else m_pc = `WORD'(t);
        end
      end else if (stall) begin
        m_pc = m_pc;
      end else if (longint'(m_pc) + 4 >= MEM) begin
        m_cnt = m_cnt + 1; m_phase = "HALT";
      end else begin
        m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pc", pc, m_pc);
    check("fetch_count", fetch_count, m_cnt);
    check("fetch_valid", `WORD'(fetch_valid), `WORD'(m_phase == "RUN"));
    check("halted", `WORD'(halted), `WORD'(m_phase == "HALT"));
    check("fault", `WORD'(fault), `WORD'(m_fault));
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [`WORD-1:0] t);
    rst = r; stall = s; branch_taken = b; branch_target = t;
  endtask

  task automatic reset_and_start();
    drive(1'b1, 1'b0, 1'b0, '0); step();
    drive(1'b0, 1'b0, 1'b0, '0); step();
  endtask

  initial begin
    int k;
    #2;
    // Reset then START cycle
    drive(1'b1, 1'b0, 1'b0, '0); step();
    check("rst_pc", pc, 0);
    check("rst_valid", `WORD'(fetch_valid), 0);
    check("rst_count", fetch_count, 0);
    drive(1'b0, 1'b0, 1'b0, '0); step();
    check("start_to_run_valid", `WORD'(fetch_valid), 1);
    check("start_to_run_pc", pc, 0);
    for (int i = 0; i < 3; i++) step();
    check("inc_pc12", pc, 12);
    check("inc_cnt3", fetch_count, 3);

    // Stall two cycles then release
    drive(1'b0, 1'b1, 1'b0, '0); step(); step();
    check("stall_pc", pc, 12);
    check("stall_cnt", fetch_count, 3);
    drive(1'b0, 1'b0, 1'b0, '0); step();
    check("release_pc", pc, 16);
    check("release_cnt", fetch_count, 4);

    // Branch beats stall
    drive(1'b0, 1'b1, 1'b1, `WORD'(52)); step();
    check("br_over_stall_pc", pc, 52);
    check("br_over_stall_cnt", fetch_count, 5);
    drive(1'b0, 1'b0, 1'b0, '0); step();
    check("after_br_pc", pc, 56);

    // Free-run to the last word, bounded
    k = 0;
    while (pc != 252 && k < 80) begin step(); k++; end
    check("reach_252", pc, 252);
    step();
    check("eom_halted", `WORD'(halted), 1);
    check("eom_valid", `WORD'(fetch_valid), 0);
    check("eom_pc", pc, 252);
    drive(1'b0, 1'b0, 1'b1, `WORD'(28)); step();
    check("halt_ignores_br", pc, 252);

    // Out-of-range branch from pc=8
    reset_and_start();
    step(); step();
    check("pre_oor_pc", pc, 8);
    drive(1'b0, 1'b0, 1'b1, `WORD'(300)); step();
    check("oor_halted", `WORD'(halted), 1);
    check("oor_pc", pc, 8);

    // Misaligned target 0x1E
    reset_and_start();
    drive(1'b0, 1'b0, 1'b1, `WORD'(32'h1E)); step();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_fault", `WORD'(fault), 1);
    check("mis_halted", `WORD'(halted), 1);
    check("mis_pc", pc, 0);
`else
    check("mis_pc", pc, 28);
    check("mis_fault", `WORD'(fault), 0);
`endif

    // Reset while stalled at pc=52
    drive(1'b1, 1'b0, 1'b0, '0); step();
    drive(1'b0, 1'b0, 1'b0, '0); step();
    drive(1'b0, 1'b0, 1'b1, `WORD'(52)); step();
    check("pre_rst_pc", pc, 52);
    drive(1'b1, 1'b1, 1'b0, '0); step();
    check("mid_rst_pc", pc, 0);
    check("mid_rst_cnt", fetch_count, 0);
    check("mid_rst_halted", `WORD'(halted), 0);
    check("mid_rst_valid", `WORD'(fetch_valid), 0);

    // Reset from HALT
    drive(1'b0, 1'b0, 1'b0, '0); step();
    drive(1'b0, 1'b0, 1'b1, `WORD'(1000)); step();
    check("pre_rst_halt", `WORD'(halted), 1);
    drive(1'b1, 1'b0, 1'b1, `WORD'(8)); step();
    check("halt_rst_pc", pc, 0);
    check("halt_rst_halted", `WORD'(halted), 0);
    check("halt_rst_fault", `WORD'(fault), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic             r;
      logic [`WORD-1:0] t;
      r = (m_phase == "HALT") ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 2);
      case ($urandom_range(0, 3))
        0: t = `WORD'($urandom_range(0, 63) * 4);
        1: t = `WORD'($urandom_range(0, 255));
        2: t = `WORD'($urandom_range(256, 400));
        default: t = `WORD'($urandom);
      endcase
      drive(r, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 8), t);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter stage directly upstream of the instruction memory in the fetch stage.
- Holds the PC and drives it to instr_mem's pc input; the instruction returns one cycle later.
- Advances the PC by 4 each cycle, or redirects on a taken branch.
- Supports a fetch stall, halts at the end of instruction memory, and counts consumed instructions.

Parameters:
- RESET_PC, 0, byte address loaded on reset.
- MEM_BYTES, 256, instruction memory size in bytes (64 words × 4); addresses >= MEM_BYTES are out of range.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- stall  input  1  downstream not ready; hold PC.
- branch_taken  input  1  redirect request for the next cycle.
- branch_target  input  `WORD  redirect byte address.
- pc  output  `WORD  current fetch address, drives instr_mem.
- fetch_valid  output  1  the instruction at pc is valid for downstream this cycle.
- halted  output  1  fetch has stopped; sticky until rst.
- fault  output  1  misaligned-target trap (see Optional Feature).
- fetch_count  output  `WORD  number of instructions consumed since reset.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at edge):
  - pc=RESET_PC, fetch_valid=0, halted=0, fault=0, fetch_count=0.
  - state=START.
  - Reset overrides every other input, in any state, including mid-stall or HALT.
- States:
  - START: one cycle so instr_mem can produce its first word. pc holds, fetch_valid=0. branch_taken and stall are ignored. Next state is RUN.
  - RUN: fetch_valid=1. Per edge, first matching rule wins:
    1. branch_taken=1, target in range and aligned: pc<=target, fetch_count+1. Branch wins over stall.
    2. branch_taken=1, target >= MEM_BYTES: pc holds, fetch_count+1, state<=HALT.
    3. stall=1: pc, fetch_count hold.
    4. pc+4 >= MEM_BYTES: pc holds, fetch_count+1, state<=HALT.
    5. Otherwise: pc<=pc+4, fetch_count+1.
  - HALT: halted=1, fetch_valid=0. pc and fetch_count frozen. All inputs except rst are ignored.
- Arithmetic and width:
  - pc+4 is computed at `WORD width; the range check precedes any wrap.
  - The branch_target range check is unsigned, at full width.
  - fetch_count wraps modulo 2^`WORD.
- Alignment:
  - pc[1:0] is always 00.
  - Handling of a branch_target with nonzero low bits is defined by the Optional Feature.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a taken branch with target[1:0]!=0 (regardless of range) behaves as follows:
  - pc holds.
  - fetch_count+1.
  - fault<=1, state<=HALT.
  - fault is sticky until rst.
- Undefined:
  - The target is silently aligned (target[1:0] cleared), then the normal range rules apply.
  - fault is tied to 0.

Test Plan:
- Reset and increment: rst high 1 cycle.
  - Next cycle: pc=0, fetch_valid=0, fetch_count=0.
  - Following cycle: START→RUN, fetch_valid=1, pc=0.
  - Three free cycles later: pc=12, fetch_count=3.
- Stall: stall=1 for 2 cycles at pc=12 → pc=12, fetch_count=3 throughout. Release stall → pc=16, fetch_count=4.
- Branch wins over stall: branch_taken=1, branch_target=52, stall=1 in the same cycle → next pc=52, fetch_count incremented. Then free-run → pc=56.
- End-of-memory halt: free-run until pc=252.
  - Next edge: halted=1, fetch_valid=0, pc=252.
  - Subsequent branch_taken to 28 is ignored; pc stays 252.
  - Out-of-range branch to 300 from pc=8 also halts with pc=8.
- Misaligned target 0x1E:
  - With FETCH_MISALIGN_TRAP_EN: fault=1, halted=1, pc unchanged.
  - Without FETCH_MISALIGN_TRAP_EN: pc=28, fault=0.
- Reset mid-operation: rst asserted at pc=52 with stall=1 → next cycle pc=0, fetch_count=0, halted=0, fault=0, fetch_valid=0. Same result when rst is asserted from HALT.
